// File: rtl/hc595_pkg.sv
// Shared types and constants for the 74HC595 serial output stage.
// The optional macro HC595_LSB_FIRST_EN is consumed by hc595_driver.
package hc595_pkg;

    // Default word width: two chained 595s.
    localparam int unsigned HC595_DATA_W = 16;

    // Field layout of the 16-bit display word {segment pattern, digit select}.
    localparam int unsigned SEG_MSB = 15;
    localparam int unsigned SEG_LSB = 8;
    localparam int unsigned SEL_MSB = 7;
    localparam int unsigned SEL_LSB = 0;

    // Transfer sequencing states.
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SHIFT_LO = 3'd1,
        SHIFT_HI = 3'd2,
        LATCH    = 3'd3,
        DONE     = 3'd4
    } hc595_state_e;

    // Display word payload: active-low segments (dp in bit 0 of seg_n), digit select.
    typedef struct packed {
        logic [7:0] seg_n;
        logic [7:0] sel;
    } hc595_word_t;

endpackage

// File: rtl/hc595_phase_cnt.sv
// CLK_DIV down-counter timing each FSM phase; reload on every state change,
// expire_c pulses for one cycle when the phase has lasted CLK_DIV cycles.
module hc595_phase_cnt
    import hc595_pkg::*;
#(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic reload,
    output logic expire_c
);

    localparam int unsigned PH_W = $clog2(CLK_DIV + 1);

    logic [PH_W-1:0] cnt_q;
    logic [PH_W-1:0] cnt_d;
    logic            armed_q;
    logic            armed_d;

    // Next count: reload to CLK_DIV-1, count down, stop at zero (no wrap).
    always_comb begin
        cnt_d   = cnt_q;
        armed_d = armed_q;
        if (reload) begin
            cnt_d   = PH_W'(CLK_DIV - 1);
            armed_d = 1'b1;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - PH_W'(1);
        end else begin
            armed_d = 1'b0;
        end
    end

    // Counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            armed_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            armed_q <= armed_d;
        end
    end

    assign expire_c = armed_q && (cnt_q == '0);

endmodule

// File: rtl/hc595_driver.sv
// Serializes a parallel word into two daisy-chained 74HC595s, then pulses
// the storage latch. Define HC595_LSB_FIRST_EN to shift LSB first.
module hc595_driver
    import hc595_pkg::*;
#(
    parameter int unsigned DATA_W  = HC595_DATA_W,
    parameter int unsigned CLK_DIV = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              ds,
    output logic              shcp,
    output logic              stcp,
    output logic              done
);

    localparam int unsigned BIT_W = $clog2(DATA_W);

`ifdef HC595_LSB_FIRST_EN
    localparam int unsigned OUT_BIT = 0;
`else
    localparam int unsigned OUT_BIT = DATA_W - 1;
`endif

    hc595_state_e      state_q;
    hc595_state_e      state_d;
    logic [DATA_W-1:0] sr_q;
    logic [DATA_W-1:0] sr_d;
    logic [BIT_W-1:0]  bit_q;
    logic [BIT_W-1:0]  bit_d;
    logic              ds_q;
    logic              ds_d;
    logic              shcp_q;
    logic              shcp_d;
    logic              stcp_q;
    logic              stcp_d;
    logic              done_q;
    logic              done_d;

    logic              phase_reload_c;
    logic              phase_expire_c;

    // Phase timer shared by all timed states.
    hc595_phase_cnt #(
        .CLK_DIV (CLK_DIV)
    ) u_phase_cnt (
        .clk      (clk),
        .rst      (rst),
        .reload   (phase_reload_c),
        .expire_c (phase_expire_c)
    );

    // Next state, shift register, bit counter and next registered outputs.
    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        bit_d   = bit_q;
        ds_d    = 1'b0;
        shcp_d  = 1'b0;
        stcp_d  = 1'b0;
        done_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sr_d    = in_data;
                    bit_d   = BIT_W'(DATA_W - 1);
                    state_d = SHIFT_LO;
                end
            end
            SHIFT_LO: begin
                if (phase_expire_c) begin
                    state_d = SHIFT_HI;
                end
            end
            SHIFT_HI: begin
                if (phase_expire_c) begin
                    if (bit_q != '0) begin
`ifdef HC595_LSB_FIRST_EN
                        sr_d = {1'b0, sr_q[DATA_W-1:1]};
`else
                        sr_d = {sr_q[DATA_W-2:0], 1'b0};
`endif
                        bit_d   = bit_q - BIT_W'(1);
                        state_d = SHIFT_LO;
                    end else begin
                        state_d = LATCH;
                    end
                end
            end
            LATCH: begin
                if (phase_expire_c) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs follow the state being entered so they are registered yet aligned.
        unique case (state_d)
            SHIFT_LO: begin
                ds_d = sr_d[OUT_BIT];
            end
            SHIFT_HI: begin
                ds_d   = sr_d[OUT_BIT];
                shcp_d = 1'b1;
            end
            LATCH: begin
                stcp_d = 1'b1;
            end
            DONE: begin
                done_d = 1'b1;
            end
            default: begin
                ds_d = 1'b0;
            end
        endcase
    end

    assign phase_reload_c = (state_d != state_q);

    // State and output registers; reset returns everything to idle at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sr_q    <= '0;
            bit_q   <= '0;
            ds_q    <= 1'b0;
            shcp_q  <= 1'b0;
            stcp_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            bit_q   <= bit_d;
            ds_q    <= ds_d;
            shcp_q  <= shcp_d;
            stcp_q  <= stcp_d;
            done_q  <= done_d;
        end
    end

    assign in_ready = (state_q == IDLE);
    assign ds       = ds_q;
    assign shcp     = shcp_q;
    assign stcp     = stcp_q;
    assign done     = done_q;

endmodule
